jtkcpu_idxea: RTL
=================

Name: jtkcpu_idxea

Overview:
Sequential indexed-addressing unit for the jtkcpu core. It takes an indexed postbyte, fetches any 8/16-bit offset bytes and indirect pointer over the CPU byte bus, and produces the effective address. It also produces the auto-increment/decrement write-back for the index register. It sits between the instruction sequencer and the register file/bus arbiter, replacing purely combinational postbyte decoding.

Parameters:
AW, 16, address and index-register width (16..24)
IND_EN, 1, 1 = indirect modes supported; 0 = indirect postbytes flagged illegal

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
start  in  1  postbyte valid; accepted only when busy=0
postbyte  in  8  indexed postbyte
pc  in  AW  address of byte following postbyte
idx_x, idx_y, idx_u, idx_s  in  AW each  index register values
acc_a, acc_b  in  8  accumulators
bus_req  out  1  byte read request
bus_addr  out  AW  read address, stable while bus_req=1
bus_ack  in  1  read complete; bus_din valid this cycle
bus_din  in  8  read data
busy  out  1  operation in progress
ea_vld  out  1  one-cycle pulse: ea valid
ea  out  AW  effective address, held until next ea_vld
pc_adv  out  2  offset bytes consumed (0/1/2), valid with ea_vld
wb_en  out  1  index write-back pulse, coincident with ea_vld
wb_sel  out  2  0=X,1=Y,2=U,3=S
wb_val  out  AW  write-back value
illegal  out  1  one-cycle pulse instead of ea_vld on an undefined mode

Behaviour:
- Reset: state IDLE. busy, bus_req, ea_vld, wb_en and illegal are 0. bus_addr, ea, wb_val, pc_adv and wb_sel are 0.
- Decode: reg = postbyte[6:5].
  - postbyte[7]=0: 5-bit signed offset postbyte[4:0], no indirect.
  - Otherwise mode = postbyte[3:0] and indirect = postbyte[4].
- Modes:
  - 0000 ,R+ (EA=R, wb=R+1)
  - 0001 ,R++ (EA=R, wb=R+2)
  - 0010 ,-R (EA=R-1, wb=R-1)
  - 0011 ,--R (EA=R-2, wb=R-2)
  - 0100 ,R
  - 0101 B,R
  - 0110 A,R
  - 1000 n8,R
  - 1001 n16,R
  - 1011 D,R
  - 1100 n8,PC
  - 1101 n16,PC
  - 1111 [n16]: extended, indirect=1 required
- Illegal: 0111, 1010, 1110; 1111 with indirect=0; indirect with 0000/0010; any indirect when IND_EN=0.
- Arithmetic:
  - All sums are modulo 2^AW.
  - A, B, n5 and n8 are sign-extended. D={A,B} and n16 are sign-extended to AW.
  - PC-relative base is pc+pc_adv.
- States: IDLE -> (OFS_HI) -> OFS_LO -> CALC -> (IND_HI -> IND_LO) -> DONE -> IDLE.
  - n8 modes use OFS_LO only. n16 modes fetch the high byte at pc, then the low byte at pc+1.
  - Indirect reads the high byte at EA, then the low byte at EA+1, and the pointer becomes ea. Indirect with ,R++/,--R still writes back.
  - In DONE: ea_vld=1 (or illegal=1), wb_en where applicable; busy falls the next cycle.
  - illegal is raised from CALC directly, with no bus activity and no wb.
- busy=1 from the cycle after start through DONE.
- Minimum latency is start edge -> ea_vld 2 cycles later (IDLE, CALC, DONE).
- Bus:
  - bus_req is asserted with bus_addr in the fetch state and held until the bus_ack cycle. Data is captured on that edge.
  - bus_req deasserts the following cycle unless the next fetch starts immediately.
  - bus_ack while bus_req=0 is ignored.
- start while busy is ignored; inputs pc, idx_*, acc_* are sampled in CALC and must stay stable.
- Reset mid-operation: immediate return to IDLE, outputs to reset values, no wb pulse.

Decomposition:
- Shared package jtkcpu_pkg holds:
  - mode encodings (IDX_POSTINC1 … IDX_EXTIND)
  - register indices REG_X..REG_S
  - state encodings
- One sub-module: jtkcpu_idxmode, a combinational postbyte -> {mode, reg, use_pc, nbytes, indirect, illegal} decoder.
- The sequencer and adder live in jtkcpu_idxea.

Test Plan:
- Postbyte 0x1F (-1,X), X=0x1000 -> ea_vld at cycle 2, ea=0x0FFF, pc_adv=0, no bus_req, no wb.
- Postbyte 0xA1 (,Y++), Y=0xFFFF -> ea=0xFFFF, wb_en=1, wb_sel=1, wb_val=0x0001 (wrap).
- Postbyte 0x8D (n16,PC), pc=0x2000:
  - bus_din 0x80 then 0x00, bus_ack delayed 3 cycles each.
  - Expect ea=0x2002+0x8000 -> 0xA002, pc_adv=2, bus_addr 0x2000 then 0x2001.
- Postbyte 0x9F ([n16]):
  - Offset bytes 0x12, 0x34, pointer bytes 0x56, 0x78.
  - Expect reads at 0x2000, 0x2001, 0x1234, 0x1235 and ea=0x5678.
- Postbyte 0x87 -> illegal pulse, ea_vld=0, no bus_req. Repeat 0x90 with IND_EN=0 -> illegal.
- Assert rst during OFS_LO with bus_req high -> bus_req and busy drop asynchronously. The next start of 0x84 (,X) completes normally in 2 cycles.

Source files
------------

// File: rtl/jtkcpu_pkg.sv
// Shared definitions for the jtkcpu indexed-addressing unit.
//   idx_mode_e  : decoded addressing mode; the low four bits match the
//                 postbyte mode field, IDX_N5OFS marks the short 5-bit form.
//   REG_X..S    : index register selector values (postbyte[6:5]).
//   idx_state_e : sequencer states of jtkcpu_idxea.
package jtkcpu_pkg;

   typedef enum logic [4:0] {
      IDX_POSTINC1 = 5'h00,
      IDX_POSTINC2 = 5'h01,
      IDX_PREDEC1  = 5'h02,
      IDX_PREDEC2  = 5'h03,
      IDX_NOOFS    = 5'h04,
      IDX_BOFS     = 5'h05,
      IDX_AOFS     = 5'h06,
      IDX_N8OFS    = 5'h08,
      IDX_N16OFS   = 5'h09,
      IDX_DOFS     = 5'h0B,
      IDX_N8PC     = 5'h0C,
      IDX_N16PC    = 5'h0D,
      IDX_EXTIND   = 5'h0F,
      IDX_N5OFS    = 5'h10
   } idx_mode_e;

   localparam logic [1:0] REG_X = 2'd0;
   localparam logic [1:0] REG_Y = 2'd1;
   localparam logic [1:0] REG_U = 2'd2;
   localparam logic [1:0] REG_S = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_OFS_HI = 3'd1,
      ST_OFS_LO = 3'd2,
      ST_CALC   = 3'd3,
      ST_IND_HI = 3'd4,
      ST_IND_LO = 3'd5,
      ST_DONE   = 3'd6
   } idx_state_e;

endpackage

// File: rtl/jtkcpu_idxmode.sv
// Combinational indexed-postbyte decoder.
//   postbyte_i : indexed postbyte
//   mode_o     : idx_mode_e value (5 bits)
//   reg_o      : index register selector
//   use_pc_o   : base is the program counter
//   nbytes_o   : offset bytes to fetch after the postbyte (0/1/2)
//   indirect_o : result is a pointer to be dereferenced
//   illegal_o  : undefined combination of mode/indirect
module jtkcpu_idxmode
   import jtkcpu_pkg::*;
#(
   parameter bit IND_EN = 1'b1
) (
   input  logic [7:0] postbyte_i,
   output logic [4:0] mode_o,
   output logic [1:0] reg_o,
   output logic       use_pc_o,
   output logic [1:0] nbytes_o,
   output logic       indirect_o,
   output logic       illegal_o
);

   idx_mode_e mode;

   assign mode_o = mode;
   assign reg_o  = postbyte_i[6:5];

   always_comb begin
      mode       = IDX_NOOFS;
      use_pc_o   = 1'b0;
      nbytes_o   = 2'd0;
      indirect_o = 1'b0;
      illegal_o  = 1'b0;
      if (!postbyte_i[7]) begin
         mode = IDX_N5OFS;
      end else begin
         indirect_o = postbyte_i[4];
         case (postbyte_i[3:0])
            4'h0: begin
               mode      = IDX_POSTINC1;
               illegal_o = postbyte_i[4];
            end
            4'h1: mode = IDX_POSTINC2;
            4'h2: begin
               mode      = IDX_PREDEC1;
               illegal_o = postbyte_i[4];
            end
            4'h3: mode = IDX_PREDEC2;
            4'h4: mode = IDX_NOOFS;
            4'h5: mode = IDX_BOFS;
            4'h6: mode = IDX_AOFS;
            4'h8: begin
               mode     = IDX_N8OFS;
               nbytes_o = 2'd1;
            end
            4'h9: begin
               mode     = IDX_N16OFS;
               nbytes_o = 2'd2;
            end
            4'hB: mode = IDX_DOFS;
            4'hC: begin
               mode     = IDX_N8PC;
               use_pc_o = 1'b1;
               nbytes_o = 2'd1;
            end
            4'hD: begin
               mode     = IDX_N16PC;
               use_pc_o = 1'b1;
               nbytes_o = 2'd2;
            end
            4'hF: begin
               mode      = IDX_EXTIND;
               nbytes_o  = 2'd2;
               illegal_o = !postbyte_i[4];
            end
            default: illegal_o = 1'b1;
         endcase
         if (postbyte_i[4] && !IND_EN) illegal_o = 1'b1;
      end
   end

endmodule

// File: rtl/jtkcpu_idxea.sv
// Sequential indexed effective-address unit.
//   clk, rst            : clock, asynchronous active-high reset
//   start_i/postbyte_i  : postbyte strobe and value (taken only when idle)
//   pc_i                : address of the byte after the postbyte
//   idx_*_i, acc_*_i    : index registers and accumulators (sampled in CALC)
//   bus_req_o/addr_o    : byte read request, held until bus_ack_i
//   bus_ack_i/bus_din_i : read completion and data
//   busy_o              : operation in progress
//   ea_vld_o/ea_o       : effective address pulse / held value
//   pc_adv_o            : offset bytes consumed
//   wb_en_o/sel_o/val_o : index register write-back
//   illegal_o           : undefined postbyte pulse (replaces ea_vld_o)
//
// state  | meaning
// IDLE   | waiting for start
// OFS_HI | fetching high offset byte at pc
// OFS_LO | fetching low (or only) offset byte
// CALC   | add base and offset, decide indirect/illegal
// IND_HI | fetching pointer high byte at ea
// IND_LO | fetching pointer low byte at ea+1
// DONE   | result pulse, busy drops next cycle
module jtkcpu_idxea
   import jtkcpu_pkg::*;
#(
   parameter int AW     = 16,
   parameter bit IND_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic [7:0]    postbyte_i,
   input  logic [AW-1:0] pc_i,
   input  logic [AW-1:0] idx_x_i,
   input  logic [AW-1:0] idx_y_i,
   input  logic [AW-1:0] idx_u_i,
   input  logic [AW-1:0] idx_s_i,
   input  logic [7:0]    acc_a_i,
   input  logic [7:0]    acc_b_i,
   output logic          bus_req_o,
   output logic [AW-1:0] bus_addr_o,
   input  logic          bus_ack_i,
   input  logic [7:0]    bus_din_i,
   output logic          busy_o,
   output logic          ea_vld_o,
   output logic [AW-1:0] ea_o,
   output logic [1:0]    pc_adv_o,
   output logic          wb_en_o,
   output logic [1:0]    wb_sel_o,
   output logic [AW-1:0] wb_val_o,
   output logic          illegal_o
);

   idx_state_e    state_q;
   logic [7:0]    pb_q;
   logic [15:0]   ofs_q;
   logic [7:0]    ptr_hi_q;
   logic [AW-1:0] wbv_q;
   logic          bus_req_q;
   logic [AW-1:0] bus_addr_q;
   logic          busy_q;
   logic          ea_vld_q;
   logic [AW-1:0] ea_q;
   logic [1:0]    pc_adv_q;
   logic          wb_en_q;
   logic [1:0]    wb_sel_q;
   logic [AW-1:0] wb_val_q;
   logic          illegal_q;

   logic [7:0]    dec_pb;
   logic [4:0]    dec_mode_raw;
   idx_mode_e     dec_mode;
   logic [1:0]    dec_reg;
   logic          dec_use_pc;
   logic [1:0]    dec_nbytes;
   logic          dec_indirect;
   logic          dec_illegal;

   logic [AW-1:0] reg_val;
   logic [AW-1:0] base;
   logic [AW-1:0] ofs_sx;
   logic [AW-1:0] ea_d;
   logic [AW-1:0] wbv_d;
   logic          wb_app;
   logic          ack;

   // While idle the live postbyte is decoded so the first fetch can be
   // issued on the start edge; afterwards the captured copy is used.
   assign dec_pb   = (state_q == ST_IDLE) ? postbyte_i : pb_q;
   assign dec_mode = idx_mode_e'(dec_mode_raw);
   assign ack      = bus_req_q & bus_ack_i;

   jtkcpu_idxmode #(.IND_EN(IND_EN)) u_mode (
      .postbyte_i (dec_pb),
      .mode_o     (dec_mode_raw),
      .reg_o      (dec_reg),
      .use_pc_o   (dec_use_pc),
      .nbytes_o   (dec_nbytes),
      .indirect_o (dec_indirect),
      .illegal_o  (dec_illegal)
   );

   always_comb begin
      case (dec_reg)
         REG_X:   reg_val = idx_x_i;
         REG_Y:   reg_val = idx_y_i;
         REG_U:   reg_val = idx_u_i;
         default: reg_val = idx_s_i;
      endcase
   end

   always_comb begin
      ofs_sx = '0;
      case (dec_mode)
         IDX_N5OFS:              ofs_sx = AW'($signed(dec_pb[4:0]));
         IDX_PREDEC1:            ofs_sx = '1;
         IDX_PREDEC2:            ofs_sx = AW'(-2);
         IDX_BOFS:               ofs_sx = AW'($signed(acc_b_i));
         IDX_AOFS:               ofs_sx = AW'($signed(acc_a_i));
         IDX_DOFS:               ofs_sx = AW'($signed({acc_a_i, acc_b_i}));
         IDX_N8OFS, IDX_N8PC:    ofs_sx = AW'($signed(ofs_q[7:0]));
         IDX_N16OFS, IDX_N16PC,
         IDX_EXTIND:             ofs_sx = AW'($signed(ofs_q));
         default:                ofs_sx = '0;
      endcase

      // PC-relative offsets count from the end of the instruction bytes.
      if (dec_use_pc)                  base = pc_i + AW'(dec_nbytes);
      else if (dec_mode == IDX_EXTIND) base = '0;
      else                             base = reg_val;
      ea_d = base + ofs_sx;

      wb_app = 1'b1;
      case (dec_mode)
         IDX_POSTINC1: wbv_d = reg_val + AW'(1);
         IDX_POSTINC2: wbv_d = reg_val + AW'(2);
         IDX_PREDEC1,
         IDX_PREDEC2:  wbv_d = ea_d;
         default: begin
            wbv_d  = reg_val;
            wb_app = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pb_q       <= '0;
         ofs_q      <= '0;
         ptr_hi_q   <= '0;
         wbv_q      <= '0;
         bus_req_q  <= 1'b0;
         bus_addr_q <= '0;
         busy_q     <= 1'b0;
         ea_vld_q   <= 1'b0;
         ea_q       <= '0;
         pc_adv_q   <= '0;
         wb_en_q    <= 1'b0;
         wb_sel_q   <= '0;
         wb_val_q   <= '0;
         illegal_q  <= 1'b0;
      end else begin
         ea_vld_q  <= 1'b0;
         wb_en_q   <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  pb_q   <= postbyte_i;
                  busy_q <= 1'b1;
                  // Illegal postbytes never touch the bus.
                  if (dec_illegal || dec_nbytes == 2'd0) begin
                     state_q <= ST_CALC;
                  end else begin
                     bus_req_q  <= 1'b1;
                     bus_addr_q <= pc_i;
                     state_q    <= (dec_nbytes == 2'd2) ? ST_OFS_HI : ST_OFS_LO;
                  end
               end
            end
            ST_OFS_HI: begin
               if (ack) begin
                  ofs_q[15:8] <= bus_din_i;
                  bus_addr_q  <= bus_addr_q + AW'(1);
                  state_q     <= ST_OFS_LO;
               end
            end
            ST_OFS_LO: begin
               if (ack) begin
                  ofs_q[7:0] <= bus_din_i;
                  bus_req_q  <= 1'b0;
                  state_q    <= ST_CALC;
               end
            end
            ST_CALC: begin
               wbv_q <= wbv_d;
               if (dec_illegal) begin
                  illegal_q <= 1'b1;
                  state_q   <= ST_DONE;
               end else if (dec_indirect) begin
                  bus_req_q  <= 1'b1;
                  bus_addr_q <= ea_d;
                  state_q    <= ST_IND_HI;
               end else begin
                  ea_q     <= ea_d;
                  ea_vld_q <= 1'b1;
                  pc_adv_q <= dec_nbytes;
                  wb_en_q  <= wb_app;
                  wb_sel_q <= dec_reg;
                  wb_val_q <= wbv_d;
                  state_q  <= ST_DONE;
               end
            end
            ST_IND_HI: begin
               if (ack) begin
                  ptr_hi_q   <= bus_din_i;
                  bus_addr_q <= bus_addr_q + AW'(1);
                  state_q    <= ST_IND_LO;
               end
            end
            ST_IND_LO: begin
               if (ack) begin
                  bus_req_q <= 1'b0;
                  ea_q      <= AW'({ptr_hi_q, bus_din_i});
                  ea_vld_q  <= 1'b1;
                  pc_adv_q  <= dec_nbytes;
                  wb_en_q   <= wb_app;
                  wb_sel_q  <= dec_reg;
                  wb_val_q  <= wbv_q;
                  state_q   <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus_req_o  = bus_req_q;
   assign bus_addr_o = bus_addr_q;
   assign busy_o     = busy_q;
   assign ea_vld_o   = ea_vld_q;
   assign ea_o       = ea_q;
   assign pc_adv_o   = pc_adv_q;
   assign wb_en_o    = wb_en_q;
   assign wb_sel_o   = wb_sel_q;
   assign wb_val_o   = wb_val_q;
   assign illegal_o  = illegal_q;

endmodule
